audio_i2s_codec_if: RTL and testbench

Parametrised serial audio interface for the board codec, running entirely in the BCLK domain. It generates LRCK and serialises a stereo DAC frame, and deserialises a stereo ADC frame with a per-frame valid strobe. It also derives a cassette-input bit from one ADC channel using a two-sample average and a threshold comparator. It sits between the codec pins and the machine's speaker/cassette logic, and supersedes the fixed 16-bit stereo interface.

---
 rtl/audio_i2s_codec_if.sv | 205 ++++++++++++++++++++
 tb/tb_audio_i2s_codec_if.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_codec_if.sv
`default_nettype none
// ============================================================================
// Module   : audio_i2s_codec_if
// Purpose  : Left-justified serial audio interface for the board codec, all
//            in the BCLK domain. Generates LRCK, serialises a stereo DAC
//            frame from a hold/shadow register pair, deserialises a stereo
//            ADC frame with a per-frame valid strobe, and derives a cassette
//            input bit from one ADC channel (two-sample average + threshold).
//
// Ports    : BCLK          in   bit clock, all registers on posedge
//            iRST_N        in   asynchronous active-low reset
//            oAUD_LRCK     out  frame clock (0 = left slot, 1 = right slot)
//            oAUD_DACDAT   out  serial DAC data, MSB first
//            iAUD_ADCDAT   in   serial ADC data, MSB first
//            iDAC_L/R      in   next DAC sample pair (DATA_WIDTH)
//            iDAC_VALID    in   load strobe for iDAC_L/iDAC_R
//            oDAC_REQ      out  one-cycle pulse while the frame counter is 0
//            oADC_L/R      out  last complete ADC pair (DATA_WIDTH)
//            oADC_VALID    out  one-cycle pulse when a new ADC pair lands
//            oCASS_IN      out  cassette input level
//
// Config   : define CASS_HYSTERESIS_EN for a two-threshold (hysteresis)
//            cassette comparator; otherwise a single threshold CASS_HI.
//
// Revision : 1.0  initial parametrised release
// ============================================================================
module audio_i2s_codec_if #(
   parameter int                            DATA_WIDTH = 16,
   parameter int                            SLOT_WIDTH = 32,
   parameter int                            CASS_CH    = 0,
   parameter logic signed [DATA_WIDTH-1:0]  CASS_HI    = 16'sh1000,
   parameter logic signed [DATA_WIDTH-1:0]  CASS_LO    = -16'sh1000
) (
   input  logic                  BCLK,
   input  logic                  iRST_N,
   output logic                  oAUD_LRCK,
   output logic                  oAUD_DACDAT,
   input  logic                  iAUD_ADCDAT,
   input  logic [DATA_WIDTH-1:0] iDAC_L,
   input  logic [DATA_WIDTH-1:0] iDAC_R,
   input  logic                  iDAC_VALID,
   output logic                  oDAC_REQ,
   output logic [DATA_WIDTH-1:0] oADC_L,
   output logic [DATA_WIDTH-1:0] oADC_R,
   output logic                  oADC_VALID,
   output logic                  oCASS_IN
);

   localparam int              c_FRAME = 2 * SLOT_WIDTH;
   localparam int              c_CW    = $clog2(c_FRAME);
   localparam logic [c_CW-1:0] c_LAST  = c_CW'(c_FRAME - 1);
   localparam logic [c_CW-1:0] c_SLOT  = c_CW'(SLOT_WIDTH);
   localparam logic [c_CW-1:0] c_DW    = c_CW'(DATA_WIDTH);
   localparam logic [c_CW-1:0] c_ADCR  = c_CW'(SLOT_WIDTH + DATA_WIDTH);

   // ------------------------------------------------------------------------
   // Elaboration-time parameter sanity checks
   // ------------------------------------------------------------------------
   generate
      if (SLOT_WIDTH < DATA_WIDTH + 1) begin : g_badSlot
         $error("audio_i2s_codec_if: SLOT_WIDTH must be >= DATA_WIDTH+1");
      end
      if (DATA_WIDTH < 8 || DATA_WIDTH > 24) begin : g_badWidth
         $error("audio_i2s_codec_if: DATA_WIDTH must be within 8..24");
      end
      if (CASS_LO > CASS_HI) begin : g_badThresh
         $error("audio_i2s_codec_if: CASS_LO must be <= CASS_HI");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Frame counter. Every registered output is computed from the *next*
   // count so that it is valid during the cycle the counter holds that value.
   // ------------------------------------------------------------------------
   logic [c_CW-1:0] r_cnt;
   logic [c_CW-1:0] w_cntNext;
   logic            w_slotNext;
   logic [c_CW-1:0] w_posNext;
   logic [c_CW-1:0] w_posCur;
   logic            w_copy;

   assign w_copy     = (r_cnt == c_LAST);
   assign w_cntNext  = w_copy ? '0 : r_cnt + 1'b1;
   assign w_slotNext = (w_cntNext >= c_SLOT);
   assign w_posNext  = w_slotNext ? (w_cntNext - c_SLOT) : w_cntNext;
   assign w_posCur   = (r_cnt >= c_SLOT) ? (r_cnt - c_SLOT) : r_cnt;

   // ------------------------------------------------------------------------
   // DAC path: hold pair <- iDAC_*, shadow pair <- hold at frame end.
   // A pair arriving in the copy cycle bypasses the hold register so its MSB
   // appears one BCLK later.
   // ------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] r_holdL, r_holdR;
   logic [DATA_WIDTH-1:0] r_shadowL, r_shadowR;
   logic [DATA_WIDTH-1:0] w_shadowLNext, w_shadowRNext;
   logic [DATA_WIDTH-1:0] w_dacWord;
   logic [DATA_WIDTH-1:0] w_dacShifted;

   always_comb begin
      w_shadowLNext = r_shadowL;
      w_shadowRNext = r_shadowR;
      if (w_copy) begin
         w_shadowLNext = iDAC_VALID ? iDAC_L : r_holdL;
         w_shadowRNext = iDAC_VALID ? iDAC_R : r_holdR;
      end
   end

   // Shifting left by the slot position puts the wanted bit at the MSB;
   // positions at or past DATA_WIDTH shift everything out, giving the
   // required zero padding for free.
   assign w_dacWord    = w_slotNext ? w_shadowRNext : w_shadowLNext;
   assign w_dacShifted = w_dacWord << w_posNext;

   // ------------------------------------------------------------------------
   // ADC path: shift in during the data part of each slot.
   // ------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] w_shiftNext;
   logic [DATA_WIDTH-1:0] r_adcLeft;

   assign w_shiftNext = (w_posCur < c_DW) ? {r_shift[DATA_WIDTH-2:0], iAUD_ADCDAT}
                                          : r_shift;

   // ------------------------------------------------------------------------
   // Cassette detect: average of previous and current sample of one channel.
   // ------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0]        w_cassCur;
   logic [DATA_WIDTH-1:0]        r_cassPrev;
   logic signed [DATA_WIDTH:0]   w_cassSum;
   logic signed [DATA_WIDTH-1:0] w_avg;

   generate
      if (CASS_CH == 0) begin : g_cassLeft
         assign w_cassCur = oADC_L;
      end else begin : g_cassRight
         assign w_cassCur = oADC_R;
      end
   endgenerate

   // Sign-extended sum cannot overflow; dropping bit 0 is the arithmetic
   // shift right by one.
   assign w_cassSum = $signed({w_cassCur[DATA_WIDTH-1], w_cassCur})
                    + $signed({r_cassPrev[DATA_WIDTH-1], r_cassPrev});
   assign w_avg     = w_cassSum[DATA_WIDTH:1];

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge BCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_cnt       <= '0;
         oAUD_LRCK   <= 1'b0;
         oAUD_DACDAT <= 1'b0;
         oDAC_REQ    <= 1'b0;
         r_holdL     <= '0;
         r_holdR     <= '0;
         r_shadowL   <= '0;
         r_shadowR   <= '0;
         r_shift     <= '0;
         r_adcLeft   <= '0;
         oADC_L      <= '0;
         oADC_R      <= '0;
         oADC_VALID  <= 1'b0;
         r_cassPrev  <= '0;
         oCASS_IN    <= 1'b0;
      end else begin
         r_cnt       <= w_cntNext;
         oAUD_LRCK   <= w_slotNext;
         oAUD_DACDAT <= w_dacShifted[DATA_WIDTH-1];
         oDAC_REQ    <= (w_cntNext == '0);

         if (iDAC_VALID) begin
            r_holdL <= iDAC_L;
            r_holdR <= iDAC_R;
         end
         r_shadowL <= w_shadowLNext;
         r_shadowR <= w_shadowRNext;

         r_shift <= w_shiftNext;
         if (w_cntNext == c_DW) begin
            r_adcLeft <= w_shiftNext;
         end
         oADC_VALID <= (w_cntNext == c_ADCR);
         if (w_cntNext == c_ADCR) begin
            oADC_L <= r_adcLeft;
            oADC_R <= w_shiftNext;
         end

         if (oADC_VALID) begin
            r_cassPrev <= w_cassCur;
`ifdef CASS_HYSTERESIS_EN
            if (w_avg > CASS_HI) begin
               oCASS_IN <= 1'b1;
            end else if (w_avg < CASS_LO) begin
               oCASS_IN <= 1'b0;
            end
`else
            oCASS_IN <= (w_avg > CASS_HI);
`endif
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_codec_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_i2s_codec_if
// Purpose  : Directed self-checking bench for audio_i2s_codec_if with the
//            default parameters (16-bit samples, 32-bit slots). A codec
//            model drives ADC data each cycle; every cycle LRCK, DACDAT,
//            DAC_REQ and ADC_VALID are compared against hand-derived values.
//
// Revision : 1.0  initial release
// ============================================================================
module tb_audio_i2s_codec_if;

   localparam int DW = 16;
   localparam int SW = 32;

   logic          BCLK        = 1'b0;
   logic          iRST_N      = 1'b0;
   logic          iAUD_ADCDAT = 1'b0;
   logic [DW-1:0] iDAC_L      = '0;
   logic [DW-1:0] iDAC_R      = '0;
   logic          iDAC_VALID  = 1'b0;
   logic          oAUD_LRCK;
   logic          oAUD_DACDAT;
   logic          oDAC_REQ;
   logic [DW-1:0] oADC_L;
   logic [DW-1:0] oADC_R;
   logic          oADC_VALID;
   logic          oCASS_IN;

   int            nTests = 0;
   int            nFail  = 0;
   logic [DW-1:0] adcL   = '0;
   logic [DW-1:0] adcR   = '0;

   audio_i2s_codec_if #(
      .DATA_WIDTH (DW),
      .SLOT_WIDTH (SW),
      .CASS_CH    (0),
      .CASS_HI    (16'sh1000),
      .CASS_LO    (-16'sh1000)
   ) dut (
      .BCLK        (BCLK),
      .iRST_N      (iRST_N),
      .oAUD_LRCK   (oAUD_LRCK),
      .oAUD_DACDAT (oAUD_DACDAT),
      .iAUD_ADCDAT (iAUD_ADCDAT),
      .iDAC_L      (iDAC_L),
      .iDAC_R      (iDAC_R),
      .iDAC_VALID  (iDAC_VALID),
      .oDAC_REQ    (oDAC_REQ),
      .oADC_L      (oADC_L),
      .oADC_R      (oADC_R),
      .oADC_VALID  (oADC_VALID),
      .oCASS_IN    (oCASS_IN)
   );

   always #5 BCLK = ~BCLK;

   task automatic chk(input string tag, input int c,
                      input logic [31:0] obs, input logic [31:0] exp);
      nTests++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s cnt=%0d observed=0x%0h expected=0x%0h", tag, c, obs, exp);
      end
   endtask

   task automatic chkZero(input string tag);
      chk({tag, "_lrck"},   -1, {31'b0, oAUD_LRCK},   32'd0);
      chk({tag, "_dacdat"}, -1, {31'b0, oAUD_DACDAT}, 32'd0);
      chk({tag, "_req"},    -1, {31'b0, oDAC_REQ},    32'd0);
      chk({tag, "_adcl"},   -1, {16'b0, oADC_L},      32'd0);
      chk({tag, "_adcr"},   -1, {16'b0, oADC_R},      32'd0);
      chk({tag, "_valid"},  -1, {31'b0, oADC_VALID},  32'd0);
      chk({tag, "_cass"},   -1, {31'b0, oCASS_IN},    32'd0);
   endtask

   // Runs nCyc cycles of a frame. Entry point: the negedge inside cnt=0.
   // eL/eR: pair expected on DACDAT this frame. loadAt: cycle in which the
   // DAC strobe is raised (-1 = none). first: no DAC_REQ expected at cnt 0.
   task automatic runFrame(input int nCyc, input bit first,
                           input logic [DW-1:0] eL, input logic [DW-1:0] eR,
                           input int loadAt,
                           input logic [DW-1:0] ldL, input logic [DW-1:0] ldR,
                           input logic expCass);
      int            pos;
      bit            slot;
      logic [DW-1:0] w;
      for (int c = 0; c < nCyc; c++) begin
         slot = (c >= SW);
         pos  = slot ? c - SW : c;
         // codec model: MSB-first, left-justified, zero padding
         w = slot ? adcR : adcL;
         w = w << pos;
         iAUD_ADCDAT = (pos < DW) ? w[DW-1] : 1'b0;
         iDAC_VALID  = (c == loadAt);
         if (c == loadAt) begin
            iDAC_L = ldL;
            iDAC_R = ldR;
         end
         w = slot ? eR : eL;
         w = w << pos;
         chk("lrck",     c, {31'b0, oAUD_LRCK},   {31'b0, slot});
         chk("dacdat",   c, {31'b0, oAUD_DACDAT}, {31'b0, (pos < DW) ? w[DW-1] : 1'b0});
         chk("dacreq",   c, {31'b0, oDAC_REQ},    {31'b0, (c == 0) && !first});
         chk("adcvalid", c, {31'b0, oADC_VALID},  {31'b0, c == SW + DW});
         if (c == SW + DW) begin
            chk("adcl", c, {16'b0, oADC_L}, {16'b0, adcL});
            chk("adcr", c, {16'b0, oADC_R}, {16'b0, adcR});
         end
         if (c == SW + DW + 1) begin
            chk("cassin", c, {31'b0, oCASS_IN}, {31'b0, expCass});
         end
         @(negedge BCLK);
      end
   endtask

   logic [4:0] cassExp;

   initial begin
`ifdef CASS_HYSTERESIS_EN
      cassExp = 5'b01110;   // frames 9..13, MSB = frame 9
`else
      cassExp = 5'b01000;
`endif
      // ---- power-on reset
      repeat (3) @(negedge BCLK);
      chkZero("por");
      iRST_N = 1'b1;

      // ---- idle frames: LRCK 32 low / 32 high, REQ every 64, DACDAT zero
      runFrame(64, 1'b1, 16'h0000, 16'h0000, -1, 16'h0, 16'h0, 1'b0);
      runFrame(64, 1'b0, 16'h0000, 16'h0000, -1, 16'h0, 16'h0, 1'b0);
      runFrame(64, 1'b0, 16'h0000, 16'h0000, -1, 16'h0, 16'h0, 1'b0);

      // ---- DAC pair loaded at cnt=10; ADC codec drives 8001/7FFE
      adcL = 16'h8001;
      adcR = 16'h7FFE;
      runFrame(64, 1'b0, 16'h0000, 16'h0000, 10, 16'hA5C3, 16'h6000, 1'b0);
      runFrame(64, 1'b0, 16'hA5C3, 16'h6000, -1, 16'h0, 16'h0, 1'b0);
      // repeat of the same pair; a new pair arrives in the copy cycle
      runFrame(64, 1'b0, 16'hA5C3, 16'h6000, 63, 16'h1234, 16'h8765, 1'b0);
      // bypass pair must be on the wire immediately
      adcL = 16'h1234;
      adcR = 16'hCAFE;
      runFrame(64, 1'b0, 16'h1234, 16'h8765, -1, 16'h0, 16'h0, 1'b0);

      // ---- reset mid-frame at cnt=40
      adcL = 16'h0000;
      adcR = 16'h0000;
      runFrame(40, 1'b0, 16'h1234, 16'h8765, -1, 16'h0, 16'h0, 1'b0);
      iRST_N = 1'b0;
      #1;
      chkZero("rst_now");
      repeat (3) @(posedge BCLK);
      @(negedge BCLK);
      chkZero("rst_hold");
      iRST_N = 1'b1;

      // ---- cassette sequence on the left channel, DAC outputs zeros again
      adcL = 16'h2000;
      runFrame(64, 1'b1, 16'h0000, 16'h0000, -1, 16'h0, 16'h0, cassExp[4]);
      adcL = 16'h2000;
      runFrame(64, 1'b0, 16'h0000, 16'h0000, -1, 16'h0, 16'h0, cassExp[3]);
      adcL = 16'h0000;
      runFrame(64, 1'b0, 16'h0000, 16'h0000, -1, 16'h0, 16'h0, cassExp[2]);
      adcL = 16'hE000;
      runFrame(64, 1'b0, 16'h0000, 16'h0000, -1, 16'h0, 16'h0, cassExp[1]);
      adcL = 16'hE000;
      runFrame(64, 1'b0, 16'h0000, 16'h0000, -1, 16'h0, 16'h0, cassExp[0]);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
`default_nettype wire
